// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic req_id_t;

    localparam int DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin on a last-served pointer, or fixed priority to requester 0.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    req_id_t last_q;

    // Pointer at 1 means requester 0 is next in line on a conflict.
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (prio_mode || last_q) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= 1'b1;
        else if (advance && |gnt)
            last_q <= gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (IDLE -> ACCESS -> RESP).
// Optional address range check enabled by defining DMEM_ARBITER_RANGE_CHECK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_funct3,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rerr,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_funct3,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rerr,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    if (MEM_BYTES <= 0) begin : g_bad_mem_bytes
        $error("dmem_arbiter: MEM_BYTES must be positive");
    end

    state_t      state;
    req_id_t     id_q;
    logic        we_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;

    logic        idle, resp;
    logic [1:0]  gnt;
    logic        sel_we, range_err;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;

    assign idle = (state == IDLE);
    assign resp = (state == RESP);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({m1_req, m0_req} & {2{idle}}),
        .advance   (idle),
        .prio_mode (PRIO_MODE != 0),
        .gnt       (gnt)
    );

    assign sel_we    = gnt[1] ? m1_we     : m0_we;
    assign sel_addr  = gnt[1] ? m1_addr   : m0_addr;
    assign sel_wdata = gnt[1] ? m1_wdata  : m0_wdata;
    assign sel_f3    = gnt[1] ? m1_funct3 : m0_funct3;

`ifdef DMEM_ARBITER_RANGE_CHECK_EN
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    assign range_err = (sel_addr >= MEM_LIMIT);
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (|gnt) begin
                    id_q    <= gnt[1];
                    we_q    <= sel_we;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    f3_q    <= sel_f3;
                    err_q   <= range_err;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    rdata_q <= (we_q || err_q) ? '0 : mem_rd;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobe is decoded from state so an async reset kills it before the edge.
    assign mem_we     = (state == ACCESS) && we_q && !err_q;
    assign mem_a      = addr_q;
    assign mem_wd     = wdata_q;
    assign mem_funct3 = f3_q;

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = resp && !id_q;
    assign m1_rvalid = resp && id_q;
    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;
    assign m0_rerr   = m0_rvalid && err_q;
    assign m1_rerr   = m1_rvalid && err_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin instance with a byte memory model,
// plus a fixed-priority instance for starvation behaviour.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

`ifdef DMEM_ARBITER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        logic        rerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [2:0]  m0_funct3 = 0, m1_funct3 = 0;
    logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we, busy;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [2:0]  mem_funct3;

    logic [7:0] dmem    [1024] = '{default: 8'h00};
    logic [7:0] ref_mem [1024] = '{default: 8'h00};

    function automatic logic [31:0] load_val(input bit use_ref, input logic [31:0] addr,
                                             input logic [2:0] f3);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++)
            b[i] = use_ref ? ref_mem[10'(addr[9:0] + i)] : dmem[10'(addr[9:0] + i)];
        case (f3)
            F3_B:    return {{24{b[0][7]}}, b[0]};
            F3_H:    return {{16{b[1][7]}}, b[1], b[0]};
            F3_BU:   return {24'h0, b[0]};
            F3_HU:   return {16'h0, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++)
            ref_mem[10'(addr[9:0] + i)] = wd[8*i +: 8];
    endtask

    // Memory attached to the round-robin instance
    assign mem_rd = load_val(1'b0, mem_a, mem_funct3);
    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_a[9:0]] <= mem_wd[7:0];
            if (mem_funct3[1:0] != 2'b00) dmem[10'(mem_a[9:0] + 1)] <= mem_wd[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                dmem[10'(mem_a[9:0] + 2)] <= mem_wd[23:16];
                dmem[10'(mem_a[9:0] + 3)] <= mem_wd[31:24];
            end
        end
    end

    dmem_arbiter #(.PRIO_MODE(0)) u_dut (
        .clk(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
        .mem_rd(mem_rd), .busy(busy)
    );

    // Fixed-priority instance; only its grants are checked
    logic        p0_req = 0, p1_req = 0;
    logic        p0_gnt, p0_rvalid, p0_rerr, p1_gnt, p1_rvalid, p1_rerr;
    logic [31:0] p0_rdata, p1_rdata, p_mem_a, p_mem_wd;
    logic        p_mem_we, p_busy;
    logic [2:0]  p_mem_f3;
    logic [31:0] p_mem_rd = 32'h0;

    dmem_arbiter #(.PRIO_MODE(1)) u_dut_prio (
        .clk(clk), .reset(rst),
        .m0_req(p0_req), .m0_we(1'b0), .m0_addr(32'h10), .m0_wdata(32'h0),
        .m0_funct3(F3_W), .m0_gnt(p0_gnt), .m0_rvalid(p0_rvalid),
        .m0_rdata(p0_rdata), .m0_rerr(p0_rerr),
        .m1_req(p1_req), .m1_we(1'b0), .m1_addr(32'h20), .m1_wdata(32'h0),
        .m1_funct3(F3_W), .m1_gnt(p1_gnt), .m1_rvalid(p1_rvalid),
        .m1_rdata(p1_rdata), .m1_rerr(p1_rerr),
        .mem_we(p_mem_we), .mem_a(p_mem_a), .mem_wd(p_mem_wd), .mem_funct3(p_mem_f3),
        .mem_rd(p_mem_rd), .busy(p_busy)
    );

    // Response monitor: pops the scoreboard on every rvalid
    always @(negedge clk) begin
        if (!rst && (m0_rvalid || m1_rvalid)) begin
            total++;
            if (m0_rvalid && m1_rvalid) begin
                bad++;
                $display("FAIL rvalid_both: m0_rvalid=%b m1_rvalid=%b at cyc %0d", m0_rvalid, m1_rvalid, cyc);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid: m0=%b m1=%b with empty scoreboard at cyc %0d", m0_rvalid, m1_rvalid, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (m1_rvalid !== mon_e.id
                    || (m1_rvalid ? m1_rdata : m0_rdata) !== mon_e.rdata
                    || (m1_rvalid ? m1_rerr : m0_rerr) !== mon_e.rerr
                    || (m1_rvalid ? m0_rdata : m1_rdata) !== 32'h0) begin
                    bad++;
                    $display("FAIL resp: id=%0d rdata=%h rerr=%b other_rdata=%h, expected id=%0d rdata=%h rerr=%b other_rdata=0",
                             m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata, m1_rvalid ? m1_rerr : m0_rerr,
                             m1_rvalid ? m0_rdata : m1_rdata, mon_e.id, mon_e.rdata, mon_e.rerr);
                end
            end
        end
    end

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_funct3 = f3;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_funct3 = f3;
        end
    endtask

    function automatic exp_t make_exp(input int m, input logic we, input logic [31:0] addr,
                                      input logic [2:0] f3);
        exp_t e;
        e.id    = (m == 1);
        e.rerr  = RANGE_EN && (addr >= 32'd1024);
        e.rdata = (we || e.rerr) ? 32'h0 : load_val(1'b1, addr, f3);
        return e;
    endfunction

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
        bit got = 0;
        drive(m, 1'b1, we, addr, wd, f3);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_gnt : m1_gnt) begin
                got = 1;
                sb.push_back(make_exp(m, we, addr, f3));
                if (we && !(RANGE_EN && addr >= 32'd1024)) ref_write(addr, wd, f3);
            end
            @(posedge clk); #1;
        end
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL gnt_timeout: m%0d got=0 expected grant within 20 cycles", m);
        end
        drain();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, mem_we, busy, p_busy} !== 9'b0
            || m0_rdata !== 32'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ctl=%b m0_rdata=%h mem_a=%h mem_wd=%h expected all 0",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, mem_we, busy, p_busy},
                     m0_rdata, mem_a, mem_wd);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        exp_t e;
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, F3_W);
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sw_gnt: m0_gnt=%b m1_gnt=%b busy=%b expected 1 0 0", m0_gnt, m1_gnt, busy);
        end
        e = make_exp(0, 1'b1, 32'h10, F3_W);
        sb.push_back(e);
        ref_write(32'h10, 32'hDEADBEEF, F3_W);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        @(negedge clk);
        total++;
        if (mem_we !== 1'b1 || mem_a !== 32'h10 || mem_wd !== 32'hDEADBEEF || mem_funct3 !== F3_W
            || m0_rvalid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sw_access: mem_we=%b mem_a=%h mem_wd=%h f3=%b rvalid=%b busy=%b expected 1 10 deadbeef 010 0 1",
                     mem_we, mem_a, mem_wd, mem_funct3, m0_rvalid, busy);
        end
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || m0_rvalid !== 1'b1 || m0_rerr !== 1'b0) begin
            bad++;
            $display("FAIL sw_resp: mem_we=%b m0_rvalid=%b m0_rerr=%b expected 0 1 0", mem_we, m0_rvalid, m0_rerr);
        end
        @(posedge clk); #1;
        drain();
        do_req(0, 1'b0, 32'h10, 32'h0, F3_W);
    endtask

    task automatic test_byte_path();
        do_req(1, 1'b1, 32'h21, 32'h000000A5, F3_B);
        do_req(1, 1'b0, 32'h21, 32'h0, F3_B);
        do_req(1, 1'b0, 32'h21, 32'h0, F3_BU);
        do_req(1, 1'b0, 32'h20, 32'h0, F3_H);
        do_req(1, 1'b0, 32'h20, 32'h0, F3_HU);
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last_c = 0;
        bit w;
        exp_t e;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, F3_W);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, F3_W);
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                w = m1_gnt;
                total++;
                if ((m0_gnt && m1_gnt) || w !== (n % 2 == 1) || (n > 0 && cyc - last_c != 3)) begin
                    bad++;
                    $display("FAIL rr_grant%0d: m0_gnt=%b m1_gnt=%b spacing=%0d expected winner m%0d spacing 3",
                             n, m0_gnt, m1_gnt, cyc - last_c, n % 2);
                end
                e = make_exp(w ? 1 : 0, 1'b0, w ? 32'h20 : 32'h10, F3_W);
                sb.push_back(e);
                last_c = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL rr_count: grants=%0d expected 6", n);
        end
        drain();
    endtask

    task automatic test_reset_mid_write();
        drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, F3_W);
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_gnt: m0_gnt=%b expected 1", m0_gnt);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        total++;
        if (mem_we !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_access: mem_we=%b expected 1", mem_we);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || m0_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort: mem_we=%b busy=%b m0_rvalid=%b expected 0 0 0", mem_we, busy, m0_rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (m0_rvalid || m1_rvalid) begin
                bad++;
                $display("FAIL rst_mid_no_resp: m0_rvalid=%b m1_rvalid=%b expected 0 0", m0_rvalid, m1_rvalid);
            end
            @(posedge clk); #1;
        end
        do_req(0, 1'b0, 32'h40, 32'h0, F3_W);
    endtask

    task automatic test_range();
        exp_t e;
        drive(0, 1'b1, 1'b1, 32'h400, 32'hCAFEF00D, F3_W);
        @(negedge clk);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL range_gnt: m0_gnt=%b expected 1", m0_gnt);
        end
        e = make_exp(0, 1'b1, 32'h400, F3_W);
        sb.push_back(e);
        if (!RANGE_EN) ref_write(32'h400, 32'hCAFEF00D, F3_W);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
        total++;
        if (mem_a !== 32'h400 || mem_we !== !RANGE_EN) begin
            bad++;
            $display("FAIL range_access: mem_a=%h mem_we=%b expected 400 %b", mem_a, mem_we, !RANGE_EN);
        end
        drain();
        do_req(0, 1'b0, 32'h400, 32'h0, F3_W);
        do_req(1, 1'b0, 32'h3FC, 32'h0, F3_W);
    endtask

    task automatic test_fixed_prio();
        int g0 = 0;
        bit seen = 0;
        p0_req = 1'b1;
        p1_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++;
            if (p1_gnt !== 1'b0) begin
                bad++;
                $display("FAIL prio_starve: p1_gnt=%b expected 0 while m0_req=1", p1_gnt);
            end
            if (p0_gnt) g0++;
            @(posedge clk); #1;
        end
        total++;
        if (g0 != 3) begin
            bad++;
            $display("FAIL prio_m0_count: grants=%0d expected 3", g0);
        end
        p0_req = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (!p_busy) begin
                seen = 1;
                total++;
                if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
                    bad++;
                    $display("FAIL prio_m1_after_drop: p1_gnt=%b p0_gnt=%b expected 1 0", p1_gnt, p0_gnt);
                end
            end
            @(posedge clk); #1;
        end
        p1_req = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL prio_idle_timeout: no IDLE cycle seen within 6 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_path();
        test_round_robin();
        test_reset_mid_write();
        test_range();
        test_fixed_prio();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d responses outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer sharing the single-port data memory (1 KB, byte/half/word access selected by funct3, combinational read, write on clock edge).
- Requester 0 is the core load/store unit; requester 1 is the program loader/debug DMA.
- Registers the winning request, drives the memory port for exactly one cycle, then returns a registered response to the winner.
- Sits between the requesters and the data memory instance in the top level.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.
- MEM_BYTES, 1024, size of the valid data-memory window starting at address 0; used only by the optional range check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 request valid.
- m0_we  in  1  requester 0: 1 = store, 0 = load.
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 store data.
- m0_funct3  in  3  requester 0 access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- m0_gnt  out  1  request accepted this cycle.
- m0_rvalid  out  1  response valid (loads and stores), one-cycle pulse.
- m0_rdata  out  32  load data; 0 for stores.
- m0_rerr  out  1  access error, qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_funct3, m1_gnt, m1_rvalid, m1_rdata, m1_rerr  same widths and meanings for requester 1.
- mem_we  out  1  memory write enable.
- mem_a  out  32  memory address.
- mem_wd  out  32  memory write data.
- mem_funct3  out  3  memory access size.
- mem_rd  in  32  memory read data (combinational from mem_a/mem_funct3).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no req: stay IDLE.
- IDLE, any req: assert gnt (combinational) to the winner only. Capture winner id, we, addr, wdata and funct3 into registers. Go to ACCESS.
- ACCESS: drive mem_a/mem_wd/mem_funct3 from the registers and mem_we = we_q. Capture mem_rd into the rdata register on the clock edge (0 when we_q=1). Go to RESP.
- RESP: assert rvalid of the winner for exactly one cycle with the registered rdata/rerr. Go to IDLE.
- gnt asserts only in IDLE. Maximum throughput is one transaction per 3 cycles. Latency is gnt at cycle N, memory access at N+1, rvalid at N+2.
- Requester must hold req and all request fields stable until gnt. Dropping req before gnt is legal and starts no transaction. Fields are don't-care after gnt.
- Arbitration, PRIO_MODE=0:
  - Both requesting: grant the requester not served last.
  - Last-served pointer resets to 1, so requester 0 wins the first conflict.
  - Pointer updates only on a grant.
- Arbitration, PRIO_MODE=1: requester 0 wins every conflict. Requester 1 can starve (documented, intended).
- Outside ACCESS: mem_we=0; mem_a, mem_wd, mem_funct3 hold the last registered values.
- Registers and reset values:
  - The rdata register is shared; it appears only on the winner's rdata output during RESP.
  - The non-winner's rdata reads 0; all rdata outputs read 0 outside RESP.
  - All gnt, rvalid, rerr, mem_we and busy reset to 0; all data/address registers reset to 0; state resets to IDLE.
- Reset mid-operation: asynchronous reset forces IDLE immediately. If asserted during ACCESS before the edge, mem_we drops combinationally and the write does not occur. A pending response is discarded; no rvalid is issued.
- Unaligned accesses are forwarded unchanged; the memory defines their result.

Optional Feature:
- Macro: DMEM_ARBITER_RANGE_CHECK_EN.
- Defined: in IDLE a granted request with addr >= MEM_BYTES is flagged. In ACCESS, mem_we is held 0 and rdata is captured as 0. In RESP, rerr=1 with rvalid. Latency is unchanged.
- Undefined: all requests are forwarded; rerr outputs are tied 0.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - state enum type (IDLE, ACCESS, RESP);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - requester-id typedef (1 bit);
  - default MEM_BYTES constant.
- One sub-module, rr_arb2: 2-way round-robin/fixed-priority grant logic with last-served pointer. Inputs: req[1:0], advance, prio_mode. Output: one-hot grant.

Test Plan:
- Single store then load: m0 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> m0_gnt at cycle 0, mem_we high only at cycle 1, m0_rvalid at cycle 2; load returns 0xDEADBEEF, rerr=0.
- Round-robin conflict: m0 and m1 both request LW continuously, PRIO_MODE=0 -> grants alternate m0, m1, m0, m1, one every 3 cycles; the non-winner's rvalid never asserts.
- Fixed priority: PRIO_MODE=1, both request continuously -> m1_gnt stays 0 while m0_req=1; m1 is granted in the first IDLE cycle after m0_req drops.
- Byte path: m1 SB addr 0x21 wdata 0x000000A5, then m1 LB 0x21 -> rdata 0xFFFFFFA5; LBU -> 0x000000A5.
- Reset mid-write: m0 SW 0x40 0x12345678, assert reset during ACCESS before the edge -> mem_we=0, no rvalid. A later LW 0x40 returns the prior value 0x00000000.
- Range check (macro defined): m0 LW addr 0x400 -> mem_we=0, m0_rvalid with m0_rerr=1 and rdata 0. Without macro: rerr=0 and the address is forwarded.
